// File: rtl/tick_monitor_if.sv
// Tick-monitor signal bundle: tick input, measurement results and FSM debug state.
// Optional min/max period outputs exist only when TICK_MONITOR_STATS_EN is defined.
interface tick_monitor_if;
  logic        tick_in;
  logic [9:0]  period;
  logic        period_valid;
  logic        locked;
  logic        early_err;
  logic        late_err;
  logic [15:0] tick_count;
  // FSM debug state: 0 = IDLE, 1 = SEARCH, 2 = TRACK.
  logic [1:0]  fsm_state;
`ifdef TICK_MONITOR_STATS_EN
  logic [9:0]  min_period;
  logic [9:0]  max_period;

  modport master (
    output tick_in,
    input  period, period_valid, locked, early_err, late_err, tick_count, fsm_state,
    input  min_period, max_period
  );
  modport slave (
    input  tick_in,
    output period, period_valid, locked, early_err, late_err, tick_count, fsm_state,
    output min_period, max_period
  );
`else
  modport master (
    output tick_in,
    input  period, period_valid, locked, early_err, late_err, tick_count, fsm_state
  );
  modport slave (
    input  tick_in,
    output period, period_valid, locked, early_err, late_err, tick_count, fsm_state
  );
`endif
endinterface

// File: rtl/tick_monitor.sv
// Measures edge-to-edge intervals of a tick train, flags early/late ticks and tracks lock.
// Define TICK_MONITOR_STATS_EN to add running min_period/max_period outputs.
module tick_monitor #(
  parameter int EXP_PERIOD = 151,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 3
) (
  input  logic          clk_1ms,
  input  logic          reset_n,
  tick_monitor_if.slave bus
);
  localparam logic [9:0] LO_LIM  = 10'(EXP_PERIOD - TOL);
  localparam logic [9:0] HI_LIM  = 10'(EXP_PERIOD + TOL);
  localparam logic [9:0] TIMEOUT = 10'(EXP_PERIOD + TOL + 1);
  localparam logic [3:0] LOCK    = 4'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, TRACK = 2'd2} state_t;

  state_t      state;
  logic        tick_d;
  logic        tick_edge;
  logic [9:0]  cnt;
  logic [9:0]  period_q;
  logic [2:0]  good_cnt;
  logic        period_valid_q;
  logic        locked_q;
  logic        early_q;
  logic        late_q;
  logic [15:0] tick_count_q;

  assign tick_edge = bus.tick_in & ~tick_d;

  // period_valid is a one-cycle strobe with no ready: period is captured with
  // the strobe and holds until the next strobe; there is no back-pressure.
  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      tick_d         <= 1'b0;
      cnt            <= '0;
      period_q       <= '0;
      good_cnt       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      early_q        <= 1'b0;
      late_q         <= 1'b0;
      tick_count_q   <= '0;
    end else begin
      tick_d         <= bus.tick_in;
      period_valid_q <= 1'b0;
      early_q        <= 1'b0;
      late_q         <= 1'b0;

      if (tick_edge) begin
        cnt          <= 10'd1;
        tick_count_q <= tick_count_q + 16'd1;
      end else if (cnt != 10'h3FF) begin
        cnt <= cnt + 10'd1;
      end

      case (state)
        IDLE, SEARCH: begin
          if (tick_edge) state <= TRACK;
        end
        TRACK: begin
          // An edge on the timeout cycle wins: it is reported as a late period.
          if (tick_edge) begin
            period_q       <= cnt;
            period_valid_q <= 1'b1;
            if (cnt < LO_LIM) begin
              early_q  <= 1'b1;
              good_cnt <= '0;
              locked_q <= 1'b0;
            end else if (cnt > HI_LIM) begin
              late_q   <= 1'b1;
              good_cnt <= '0;
              locked_q <= 1'b0;
            end else begin
              if ({1'b0, good_cnt} < LOCK) good_cnt <= good_cnt + 3'd1;
              if (({1'b0, good_cnt} + 4'd1) >= LOCK) locked_q <= 1'b1;
            end
          end else if (cnt == TIMEOUT) begin
            late_q   <= 1'b1;
            good_cnt <= '0;
            locked_q <= 1'b0;
            state    <= SEARCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked       = locked_q;
  assign bus.early_err    = early_q;
  assign bus.late_err     = late_q;
  assign bus.tick_count   = tick_count_q;
  assign bus.fsm_state    = state;

`ifdef TICK_MONITOR_STATS_EN
  logic [9:0] min_q;
  logic [9:0] max_q;

  // Updated on the same clock that raises period_valid.
  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= 10'h3FF;
      max_q <= '0;
    end else if (state == TRACK && tick_edge) begin
      if (cnt < min_q) min_q <= cnt;
      if (cnt > max_q) max_q <= cnt;
    end
  end

  assign bus.min_period = min_q;
  assign bus.max_period = max_q;
`endif
endmodule

// File: tb/tb_tick_monitor.sv
// Self-checking bench for tick_monitor: directed scenarios plus randomized tick trains
// checked cycle by cycle against an interval-level reference model.
module tb_tick_monitor;
  localparam int EXP  = 151;
  localparam int TOL  = 2;
  localparam int LOCK = 3;

  logic clk_1ms;
  logic reset_n;

  tick_monitor_if bus ();

  tick_monitor #(.EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LOCK)) dut (
    .clk_1ms (clk_1ms),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk_1ms = 1'b0;
  always #5 clk_1ms = ~clk_1ms;

  // Scoreboard and reference model state
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  bit          prev_t;
  bit          armed;
  bit          seen;
  int          since;
  int          streak;
  logic        m_pv, m_early, m_late, m_locked;
  logic [9:0]  m_period;
  logic [15:0] m_count;
  logic [9:0]  m_min, m_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prev_t = 1'b0; armed = 1'b0; seen = 1'b0; since = 0; streak = 0;
    m_pv = 1'b0; m_early = 1'b0; m_late = 1'b0; m_locked = 1'b0;
    m_period = '0; m_count = '0; m_min = 10'h3FF; m_max = '0;
    exp_q.delete();
  endtask

  // Rules in terms of edge times: interval = cycles since the previous edge.
  task automatic model_update(input bit t);
    bit rise;
    rise = t && !prev_t;
    prev_t = t;
    m_pv = 1'b0; m_early = 1'b0; m_late = 1'b0;
    if (armed) since++;
    if (rise) begin
      m_count = m_count + 16'd1;
      seen = 1'b1;
      if (armed) begin
        m_period = 10'(since);
        m_pv = 1'b1;
        exp_q.push_back(10'(since));
        if (since < m_min) m_min = 10'(since);
        if (since > m_max) m_max = 10'(since);
        if (since < EXP - TOL) m_early = 1'b1;
        else if (since > EXP + TOL) m_late = 1'b1;
        if (m_early || m_late) begin
          streak = 0; m_locked = 1'b0;
        end else begin
          if (streak < LOCK) streak++;
          if (streak >= LOCK) m_locked = 1'b1;
        end
      end
      armed = 1'b1;
      since = 0;
    end else if (armed && since == EXP + TOL + 1) begin
      m_late = 1'b1; armed = 1'b0; streak = 0; m_locked = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [9:0] sb_exp;
    check("period_valid", 32'(bus.period_valid), 32'(m_pv));
    check("period", 32'(bus.period), 32'(m_period));
    check("early_err", 32'(bus.early_err), 32'(m_early));
    check("late_err", 32'(bus.late_err), 32'(m_late));
    check("locked", 32'(bus.locked), 32'(m_locked));
    check("tick_count", 32'(bus.tick_count), 32'(m_count));
    check("fsm_state", 32'(bus.fsm_state), armed ? 32'd2 : (seen ? 32'd1 : 32'd0));
`ifdef TICK_MONITOR_STATS_EN
    check("min_period", 32'(bus.min_period), 32'(m_min));
    check("max_period", 32'(bus.max_period), 32'(m_max));
`endif
    if (bus.period_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_period", 32'd1, 32'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_period", 32'(bus.period), 32'(sb_exp));
      end
    end
  endtask

  // Driver tasks: called at a falling edge, return at the next falling edge.
  task automatic step(input bit t);
    bus.tick_in = t;
    @(posedge clk_1ms);
    model_update(t);
    @(negedge clk_1ms);
    compare_all();
  endtask

  task automatic hold(input bit t, input int n);
    repeat (n) step(t);
  endtask

  // One pulse of 'width' high cycles; the next pulse's edge lands 'interval' cycles later.
  task automatic pulse(input int interval, input int width);
    hold(1'b1, width);
    hold(1'b0, interval - width);
  endtask

  task automatic do_reset(input bit tick_at_release);
    @(negedge clk_1ms);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_period", 32'(bus.period), 32'd0);
    check("rst_period_valid", 32'(bus.period_valid), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_early", 32'(bus.early_err), 32'd0);
    check("rst_late", 32'(bus.late_err), 32'd0);
    check("rst_tick_count", 32'(bus.tick_count), 32'd0);
`ifdef TICK_MONITOR_STATS_EN
    check("rst_min_period", 32'(bus.min_period), 32'h3FF);
    check("rst_max_period", 32'(bus.max_period), 32'd0);
`endif
    model_reset();
    bus.tick_in = tick_at_release;
    @(negedge clk_1ms);
    @(negedge clk_1ms);
    reset_n = 1'b1;
  endtask

  initial begin
    int sel, ival, width;
    reset_n     = 1'b1;
    bus.tick_in = 1'b0;
    model_reset();

    do_reset(1'b0);

    // Nominal train: lock after the fourth edge.
    repeat (5) pulse(EXP, 1);
    check("nominal_locked", 32'(bus.locked), 32'd1);

    // One short interval, then relock.
    pulse(140, 1);
    repeat (4) pulse(EXP, 1);
    check("relock_after_early", 32'(bus.locked), 32'd1);

    // Edge exactly on the timeout cycle stays in TRACK.
    pulse(154, 2);
    pulse(EXP, 1);
    pulse(EXP, 1);

    // Missing tick: single late timeout, then restart without a period.
    hold(1'b0, 300);
    pulse(EXP, 1);
    pulse(EXP, 1);

    // Tick held high: one edge, then timeout while high.
    hold(1'b1, 400);
    hold(1'b0, 5);
    pulse(EXP, 3);
    pulse(EXP, 1);

    // Randomized trains spanning early, good, late and missing ticks.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 30; k++) begin
        sel = $urandom_range(9, 0);
        if (sel < 6)       ival = $urandom_range(EXP + TOL + 2, EXP - TOL - 2);
        else if (sel < 8)  ival = EXP;
        else if (sel == 8) ival = $urandom_range(140, 100);
        else               ival = $urandom_range(260, EXP + TOL + 3);
        width = $urandom_range(4, 1);
        pulse(ival, width);
      end
      if ($urandom_range(1, 0) == 1) do_reset(1'b0);
    end

    // Reset 70 cycles into an interval aborts the measurement.
    do_reset(1'b0);
    repeat (4) pulse(EXP, 1);
    pulse(70, 1);
    do_reset(1'b0);
    hold(1'b1, 1);
    check("post_reset_no_period", 32'(bus.period_valid), 32'd0);
    check("post_reset_count", 32'(bus.tick_count), 32'd1);
    hold(1'b0, EXP - 1);
    pulse(EXP, 1);

    // tick_in already high at reset release counts on the first clock.
    do_reset(1'b1);
    hold(1'b1, 1);
    check("high_at_release_count", 32'(bus.tick_count), 32'd1);
    hold(1'b0, EXP - 1);
    pulse(EXP, 2);

    // Intervals 149, 153, 151 for the min/max statistics.
    do_reset(1'b0);
    pulse(149, 1);
    pulse(153, 1);
    pulse(EXP, 1);
    hold(1'b1, 1);
    hold(1'b0, 3);
`ifdef TICK_MONITOR_STATS_EN
    check("stats_min", 32'(bus.min_period), 32'd149);
    check("stats_max", 32'(bus.max_period), 32'd153);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 Parameter EXP_PERIOD, default 151, nominal clk_1ms cycles between tick rising edges.
REQ-002 Parameter TOL, default 2, allowed ± deviation in cycles.
REQ-003 Parameter LOCK_CNT, default 3, consecutive in-window periods required for lock.
REQ-004 clk_1ms  input  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 tick_in  input  1  tick pulse train, synchronous to clk_1ms; may be high for more than one cycle.
REQ-007 period  output  10  last measured edge-to-edge interval in cycles.
REQ-008 period_valid  output  1  one-cycle strobe; period updated.
REQ-009 locked  output  1  level; tick train is in tolerance.
REQ-010 early_err  output  1  one-cycle strobe; interval < EXP_PERIOD-TOL.
REQ-011 late_err  output  1  one-cycle strobe; interval > EXP_PERIOD+TOL or tick missing.
REQ-012 tick_count  output  16  count of rising edges since reset; wraps 0xFFFF->0.

Function
REQ-013 Edge = tick_in & ~tick_d, where tick_d is tick_in registered one cycle; only edges are counted.
REQ-014 Interval counter cnt, 10 bits: loads 1 on each edge, otherwise increments, saturating at 1023.
REQ-015 States: IDLE (no edge since reset), SEARCH (awaiting restart edge after a late timeout), TRACK.
REQ-016 IDLE/SEARCH + edge -> TRACK, cnt<=1; no period_valid, no error.
REQ-017 TRACK + edge: period<=cnt, period_valid=1 in the following cycle (latency 1 from sampled edge).
REQ-018 Classification on TRACK edge: cnt < EXP_PERIOD-TOL -> early_err; cnt > EXP_PERIOD+TOL -> late_err; else good.
REQ-019 TRACK, no edge, cnt == EXP_PERIOD+TOL+1 -> late_err one cycle, state -> SEARCH; no further late_err until re-entering TRACK.
REQ-020 Edge in same cycle as REQ-019 threshold: edge wins; period reported, single late_err, state stays TRACK.
REQ-021 good_cnt (3 bits, saturating at LOCK_CNT) increments on good period; cleared on any error or entry to SEARCH.
REQ-022 locked=1 in the cycle after good_cnt reaches LOCK_CNT; locked=0 the cycle after any early_err or late_err.
REQ-023 early_err, late_err, period_valid never asserted more than one cycle per event; early_err and late_err mutually exclusive.
REQ-024 tick_count increments on every edge in all states.
REQ-025 tick_in held high continuously yields one edge only; late timeout proceeds per REQ-019.

Reset
REQ-026 reset_n low: state=IDLE, cnt=0, tick_d=0, good_cnt=0, period=0, period_valid=0, locked=0, early_err=0, late_err=0, tick_count=0.
REQ-027 Reset asserted mid-interval aborts measurement immediately; the first edge after release behaves as REQ-016.
REQ-028 A tick_in already high at reset release counts as an edge on the first clock.

Configuration
REQ-029 Macro TICK_MONITOR_STATS_EN defined: adds outputs min_period, max_period (10 bits each), reset to 1023 and 0, updated on every period_valid, cleared by reset only.
REQ-030 Macro undefined: min_period and max_period ports and logic absent; all other behaviour identical.

Verification
REQ-031 Ticks every 151 cycles, 5 pulses -> period=151 with period_valid on edges 2..5; locked=1 the cycle after the 4th edge; no errors.
REQ-032 Locked, then one interval of 140 -> early_err 1 cycle, period=140, locked=0; 3 more 151-cycle intervals relock.
REQ-033 Locked, tick_in held low -> late_err exactly once at cnt=154, state SEARCH, locked=0; next edge gives no period_valid.
REQ-034 Edge exactly at cnt=154 -> period=154, single late_err, remains TRACK.
REQ-035 reset_n pulsed low 70 cycles into an interval -> all outputs zero asynchronously; next edge gives no period_valid; tick_count restarts from 1.
REQ-036 TICK_MONITOR_STATS_EN defined, intervals 149,153,151 -> min_period=149, max_period=153.
